// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage memory request into a single aligned
// 32-bit bus transaction and returns extended load data or an error to writeback.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [2:0]        req_size,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    input  logic              mem_resp_err
);
    localparam int SW = XLEN / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    state_e          r_state;
    state_e          w_next;
    logic            r_dir;
    logic [2:0]      r_size;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic            w_accept;
    logic            w_illegal;

    function automatic logic access_illegal(input logic dir, input logic [2:0] size,
                                            input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_BU:   bad = dir;
            SZ_H:    bad = off[0];
            SZ_HU:   bad = dir | off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [SW-1:0] store_strb(input logic [2:0] size, input logic [1:0] off);
        logic [SW-1:0] strb;
        case (size)
            SZ_B:    strb = SW'(1) << off;
            SZ_H:    strb = SW'(3) << off;
            default: strb = '1;
        endcase
        return strb;
    endfunction

    // Replicate the store lanes so the strobes alone select the target bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0] size,
                                                   input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] d;
        case (size)
            SZ_B:    d = {SW{wdata[7:0]}};
            SZ_H:    d = {(SW/2){wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [XLEN-1:0] load_data(input logic [2:0] size, input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [XLEN-1:0]    d;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            SZ_B:    d = XLEN'(b);
            SZ_BU:   d = XLEN'(sh[7:0]);
            SZ_H:    d = XLEN'(h);
            SZ_HU:   d = XLEN'(sh[15:0]);
            default: d = sh;
        endcase
        return d;
    endfunction

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_illegal = access_illegal(req_dir, req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_illegal ? S_RESP : S_REQ;
            S_REQ:   if (mem_req_ready) w_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus fields are captured once at acceptance so they hold steady through any stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir   <= 1'b0;
            r_size  <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_dir   <= req_dir;
            r_size  <= req_size;
            r_off   <= req_addr[1:0];
            r_addr  <= {req_addr[XLEN-1:2], 2'b00};
            r_wdata <= req_dir ? store_data(req_size, req_wdata) : '0;
            r_wstrb <= req_dir ? store_strb(req_size, req_addr[1:0]) : '0;
            r_rdata <= '0;
            r_err   <= w_illegal;
        end else if (r_state == S_WAIT && mem_resp_valid) begin
            r_err   <= mem_resp_err;
            r_rdata <= (!r_dir && !mem_resp_err) ? load_data(r_size, r_off, mem_resp_rdata) : '0;
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_err      = r_err;
    assign mem_addr      = r_addr;
    assign mem_we        = r_dir;
    assign mem_wstrb     = r_wstrb;
    assign mem_wdata     = r_wdata;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: loads, stores, illegal accesses,
// bus stall, bus error and reset in the middle of a transaction.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_dir = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        mem_resp_err = 1'b0;

    int checks = 0;
    int failures = 0;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Load vectors against bus word 0x80AA_BBCC.
    logic [2:0]  ld_size [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] ld_addr [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1000};
    logic [31:0] ld_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA,
                                 32'h0000_80AA, 32'hFFFF_FFBB, 32'h80AA_BBCC};

    logic [2:0]  st_size  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] st_addr  [3] = '{32'h2002, 32'h2001, 32'h2004};
    logic [31:0] st_wdata [3] = '{32'h1234_ABCD, 32'h7777_775A, 32'hCAFE_F00D};
    logic [31:0] st_eaddr [3] = '{32'h2000, 32'h2000, 32'h2004};
    logic [3:0]  st_strb  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] st_edata [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};

    logic        il_dir  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  il_size [6] = '{3'b010, 3'b101, 3'b011, 3'b001, 3'b100, 3'b111};
    logic [31:0] il_addr [6] = '{32'h3001, 32'h3000, 32'h3000, 32'h3003, 32'h3000, 32'h3000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic dir, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_dir   = dir;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, mem_req_valid, resp_valid, resp_err, mem_we} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=10000",
                     {req_ready, mem_req_valid, resp_valid, resp_err, mem_we});
        end
        checks++;
        if ({mem_wstrb, mem_addr, mem_wdata, resp_rdata} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data strb=%h addr=%h wdata=%h rdata=%h exp all zero",
                     mem_wstrb, mem_addr, mem_wdata, resp_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_extract();
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = 1'b1;
            drive_req(1'b0, ld_size[i], ld_addr[i], 32'hFFFF_FFFF);
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("FAIL load%0d_ready got=%b exp=1", i, req_ready);
            end
            tick();
            req_valid = 1'b0;
            checks++;
            if ({mem_req_valid, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h1000}) begin
                failures++;
                $display("FAIL load%0d_bus vld=%b we=%b strb=%b addr=%h exp 1 0 0000 00001000",
                         i, mem_req_valid, mem_we, mem_wstrb, mem_addr);
            end
            tick();
            checks++;
            if ({mem_req_valid, resp_valid} !== 2'b00) begin
                failures++;
                $display("FAIL load%0d_wait got=%b exp=00", i, {mem_req_valid, resp_valid});
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'h80AA_BBCC;
            tick();
            mem_resp_valid = 1'b0;
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, ld_exp[i]}) begin
                failures++;
                $display("FAIL load%0d_resp vld=%b err=%b rdata=%h exp 1 0 %h",
                         i, resp_valid, resp_err, resp_rdata, ld_exp[i]);
            end
            tick();
            checks++;
            if ({resp_valid, req_ready} !== 2'b01) begin
                failures++;
                $display("FAIL load%0d_after got=%b exp=01", i, {resp_valid, req_ready});
            end
        end
    endtask

    task automatic test_store();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, st_size[i], st_addr[i], st_wdata[i]);
            tick();
            req_valid = 1'b0;
            checks++;
            if ({mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, st_strb[i], st_eaddr[i], st_edata[i]}) begin
                failures++;
                $display("FAIL store%0d_bus vld=%b we=%b strb=%b addr=%h wdata=%h exp 1 1 %b %h %h",
                         i, mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
                         st_strb[i], st_eaddr[i], st_edata[i]);
            end
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'hDEAD_BEEF;
            tick();
            mem_resp_valid = 1'b0;
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
                failures++;
                $display("FAIL store%0d_resp vld=%b err=%b rdata=%h exp 1 0 00000000",
                         i, resp_valid, resp_err, resp_rdata);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        // Stray bus responses while idle must never be taken as a completion.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            drive_req(il_dir[i], il_size[i], il_addr[i], 32'h5555_5555);
            tick();
            req_valid = 1'b0;
            checks++;
            if ({resp_valid, resp_err, mem_req_valid, resp_rdata} !== {3'b110, 32'h0}) begin
                failures++;
                $display("FAIL illegal%0d_resp vld=%b err=%b memvld=%b rdata=%h exp 1 1 0 00000000",
                         i, resp_valid, resp_err, mem_req_valid, resp_rdata);
            end
            tick();
            checks++;
            if ({resp_valid, req_ready, mem_req_valid} !== 3'b010) begin
                failures++;
                $display("FAIL illegal%0d_after got=%b exp=010", i,
                         {resp_valid, req_ready, mem_req_valid});
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        mem_req_ready = 1'b0;
        drive_req(1'b1, 3'b010, 32'h4008, 32'h1122_3344);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_req_ready = 1'b1;
            checks++;
            if ({mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata, req_ready, resp_valid} !==
                {1'b1, 1'b1, 4'hF, 32'h4008, 32'h1122_3344, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall%0d_bus vld=%b we=%b strb=%b addr=%h wdata=%h rdy=%b resp=%b",
                         k, mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
                         req_ready, resp_valid);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'h0BAD_0BAD;
            end else begin
                mem_resp_valid = 1'b0;
            end
            if (resp_valid) pulses++;
            if (k < 2) begin
                checks++;
                if ({mem_req_valid, req_ready} !== 2'b00) begin
                    failures++;
                    $display("FAIL stall_wait%0d got=%b exp=00", k, {mem_req_valid, req_ready});
                end
            end
            if (k == 2) begin
                checks++;
                if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
                    failures++;
                    $display("FAIL stall_resp vld=%b err=%b rdata=%h exp 1 0 00000000",
                             resp_valid, resp_err, resp_rdata);
                end
            end
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL stall_pulses got=%0d exp=1", pulses);
        end
        mem_req_ready = 1'b1;
    endtask

    task automatic test_bus_err();
        drive_req(1'b0, 3'b010, 32'h5000, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL bus_err vld=%b err=%b rdata=%h exp 1 1 00000000",
                     resp_valid, resp_err, resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, 3'b010, 32'h6004, 32'hA5A5_A5A5);
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_req_valid, resp_valid, resp_err, mem_we, mem_wstrb,
             mem_addr, mem_wdata, resp_rdata} !== {5'b10000, 100'd0}) begin
            failures++;
            $display("FAIL reset_mid_drop rdy=%b vld=%b resp=%b we=%b strb=%b addr=%h wdata=%h",
                     req_ready, mem_req_valid, resp_valid, mem_we, mem_wstrb, mem_addr, mem_wdata);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hAAAA_5555;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({resp_valid, req_ready, mem_req_valid} !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid_late1 got=%b exp=010", {resp_valid, req_ready, mem_req_valid});
        end
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_late2 got=%b exp=01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 3'b000, 32'h7001, 32'h0);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h7000}) begin
            failures++;
            $display("FAIL b2b_bus vld=%b addr=%h exp 1 00007000", mem_req_valid, mem_addr);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_7F00;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0000_007F}) begin
            failures++;
            $display("FAIL b2b_resp vld=%b err=%b rdata=%h exp 1 0 0000007f",
                     resp_valid, resp_err, resp_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_store();
        test_illegal();
        test_stall();
        test_bus_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the execute stage and the data-memory bus.
- Consumes a memory request from execute: direction (mem_dir_e), size (mem_size_e), byte address and store data.
- Issues one aligned 32-bit word transaction on a valid/ready bus with byte strobes.
- Returns lane-extracted, sign/zero-extended load data, or an error for misaligned or illegal accesses, back to writeback (WB_MEM).

Parameters:
- XLEN, 32, data/address width. Only 32 is supported; strobe width is XLEN/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_dir  in  1  mem_dir_e: MEM_READ=0, MEM_WRITE=1.
- req_size  in  3  mem_size_e: B=000, H=001, W=010, BU=100, HU=101.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low bytes are used.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size, or bus error.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_addr  out  XLEN  word address, {addr[XLEN-1:2], 2'b00}.
- mem_we  out  1  write enable.
- mem_wstrb  out  XLEN/8  byte strobes; 0 for reads.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_resp_valid  in  1  bus response.
- mem_resp_rdata  in  XLEN  read word.
- mem_resp_err  in  1  bus error, sampled with mem_resp_valid.

Behaviour:
- State machine: IDLE, REQ, WAIT, RESP.
  - IDLE:
    - req_valid && req_ready latches dir, size, addr, wdata.
    - Legal access -> REQ. Illegal access -> RESP with the error flag set.
  - REQ:
    - mem_req_valid=1.
    - mem_addr/we/wstrb/wdata stay stable until mem_req_ready.
    - On handshake -> WAIT.
  - WAIT:
    - On mem_resp_valid -> RESP; latch the extracted data and mem_resp_err.
    - mem_resp_valid is ignored in every other state.
  - RESP:
    - resp_valid=1 for exactly one cycle, then -> IDLE.
    - No backpressure: execute must consume the response in that cycle.
- Illegal accesses (no bus transaction):
  - Sizes 011, 110, 111 in either direction.
  - BU/HU with MEM_WRITE.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Response: resp_err=1, resp_rdata=0.
- Latency:
  - Request accepted at cycle T; mem_req_valid at T+1.
  - With zero-wait handshake and response at T+2, resp_valid is at T+3.
  - Illegal access: resp_valid at T+1.
- Store formatting (off = addr[1:0]):
  - B: wstrb = 0001<<off, wdata = {4{wdata[7:0]}}.
  - H: wstrb = 0011<<off, wdata = {2{wdata[15:0]}}.
  - W: wstrb = 1111, wdata unchanged.
- Load extraction:
  - Shift word right by 8*off, then extend.
  - B: sign-extend bit 7. BU: zero-extend bits 7:0.
  - H: sign-extend bit 15. HU: zero-extend bits 15:0.
  - W: full word.
- Store response: resp_rdata=0; resp_err=mem_resp_err.
- Bus error on a load: resp_err=1, resp_rdata=0.
- Reset values:
  - State = IDLE, so req_ready=1.
  - mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata = 0.
  - resp_valid, resp_err, resp_rdata = 0.
- Reset mid-operation (any state): immediately return to IDLE and drop mem_req_valid. A bus response for the abandoned request must not produce resp_valid.
- req_* inputs are don't-care outside the IDLE handshake cycle.

Test Plan:
- Load B at addr 0x1003, bus returns 0x80AA_BBCC:
  - mem_addr=0x1000, wstrb=0, resp_rdata=0xFFFF_FF80.
  - BU from the same address and word gives 0x0000_0080.
- Store H at addr 0x2002, wdata=0x1234_ABCD:
  - mem_addr=0x2000, wstrb=1100, mem_wdata=0xABCD_ABCD, mem_we=1, resp_rdata=0.
- Load W at 0x3001:
  - No mem_req_valid; resp_valid at T+1 with resp_err=1, resp_rdata=0.
  - Same result for store HU at 0x3000.
- Bus stall: mem_req_ready low for 3 cycles, mem_resp_valid 2 cycles later:
  - mem_req outputs stable throughout; req_ready low throughout; single resp_valid pulse.
- Load W with mem_resp_err=1 -> resp_err=1, resp_rdata=0.
- Assert rst_n low while in WAIT:
  - All outputs drop at once; the late mem_resp_valid is ignored; req_ready=1 after release.
